sprite_draw_scheduler: RTL and testbench
========================================

// Module: sprite_draw_scheduler
// PURPOSE
//  Sequences N sprite engines (player, aliens, bullets) that share one VGA adapter plot port.
//  Each frame_tick runs two passes over enabled slots in index order:
//    pass 1 erases every slot; pass 2 draws every slot.
//  Only one slot owns the VGA x/y/colour/plot lines at a time.
//  Sits between the frame pacer and the sprite engines/VGA adapter.
// PARAMETERS
//  N_SLOTS         3    number of sprite engines (1..8)
//  X_W             9    x coordinate width
//  Y_W             8    y coordinate width
//  COL_W           3    colour width
//  TIMEOUT_CYCLES  255  watchdog limit per op (used only with SCHED_TIMEOUT_EN)
// PORTS
//  clk           in   1              system clock
//  reset         in   1              async, active-high
//  frame_tick    in   1              1-cycle pulse: start a frame
//  slot_en       in   N_SLOTS        per-slot enable; sampled at frame start
//  slot_done     in   N_SLOTS        engine i finished current draw/erase
//  slot_x        in   N_SLOTS*X_W    packed engine x, slot i at [i*X_W +: X_W]
//  slot_y        in   N_SLOTS*Y_W    packed engine y
//  slot_colour   in   N_SLOTS*COL_W  packed engine colour
//  draw_signal   out  N_SLOTS        one-hot level: slot i is drawing
//  erase_signal  out  N_SLOTS        one-hot level: slot i is erasing
//  vga_x         out  X_W            muxed x of active slot
//  vga_y         out  Y_W            muxed y of active slot
//  vga_colour    out  COL_W          muxed colour of active slot
//  vga_plot      out  1              write enable to VGA adapter
//  busy          out  1              frame in progress
//  frame_done    out  1              1-cycle pulse at end of frame
//  overrun       out  1              sticky: a tick was dropped
//  timeout_err   out  1              sticky: watchdog fired
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, pass=ERASE, pending=0. All outputs 0.
//   Async assertion mid-op drops all draw/erase lines in the same cycle.
//  FSM states:
//   IDLE:    (frame_tick|pending) -> en_q<=slot_en, pass=ERASE, idx=0, pending<=0, SELECT.
//   SELECT:  en_q[idx] ? ISSUE : ADVANCE.
//   ISSUE:   raise draw_signal[idx] or erase_signal[idx] per pass (registered) -> WAIT.
//   WAIT:    hold signal; vga_plot=1; vga_* = slot idx; slot_done[idx] -> RELEASE.
//   RELEASE: drop signal, vga_plot=0 -> ADVANCE. The 1-cycle gap guarantees a fresh rising edge.
//   ADVANCE: idx<N_SLOTS-1 -> idx+1, SELECT.
//            Else ERASE pass -> pass=DRAW, idx=0, SELECT.
//            Else DRAW pass -> DONE.
//   DONE:    frame_done=1 for 1 cycle -> IDLE.
//  busy=1 in every state except IDLE.
//  Outside WAIT: vga_x/y/colour hold their last value; vga_plot=0.
//  draw_signal|erase_signal is at most one-hot across both vectors, always.
//  slot_done from non-active slots is ignored; slot_done[idx] in ISSUE is ignored (seen in WAIT).
//  slot_en changes mid-frame take effect next frame only.
//  All slots disabled: frame still runs SELECT/ADVANCE scans, then frame_done.
//  frame_tick while busy: set pending (at most one queued tick).
//   A tick while pending=1 sets overrun; that tick is dropped.
//  frame_tick in the same cycle DONE->IDLE: the tick is queued as pending, not lost.
//  idx counter width $clog2(N_SLOTS) (min 1); watchdog counter 8 bits, saturating.
// CONFIGURATION
//  SCHED_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES with no slot_done:
//   set timeout_err, go to RELEASE, continue with next slot.
//   Counter clears on ISSUE.
//  Not defined: WAIT waits indefinitely; timeout_err tied 0; no counter logic.
// STRUCTURE
//  Package sprite_sched_pkg: state encoding localparams, X_W/Y_W/COL_W defaults,
//   PASS_ERASE/PASS_DRAW constants.
//  Sub-module sprite_slot_mux: combinational select of slot_x/y/colour by idx, feeding the output registers.
//  The FSM, pending/overrun logic and watchdog live in the top module.
// TESTING
//  1. N=3, en=3'b111, tick; each done 40 cycles after its signal rises ->
//     erase 0,1,2 then draw 0,1,2; exactly one frame_done; busy low after.
//  2. en=3'b101 -> slot 1 never signalled; order E0,E2,D0,D2.
//     en changed to 3'b111 mid-frame -> no effect until next tick.
//  3. Second tick during busy -> pending, frame 2 auto-starts after DONE.
//     Third tick while pending -> overrun=1, only 2 frames run.
//  4. Async reset asserted in WAIT of slot 1 ->
//     all draw/erase/vga_plot/busy=0 immediately; next tick restarts at E0.
//  5. Back-to-back ops on the same slot (N=1) -> draw_signal low >=1 cycle after erase, rising edge present.
//     vga_* equals slot_x/y/colour while plot=1.
//  6. SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, slot 0 never done -> timeout_err=1 at cycle 16 of WAIT;
//     frame completes, frame_done pulses.

Source files
------------

// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite draw scheduler: FSM state encoding,
// pass identifiers, default coordinate/colour widths and the slot-index width helper.
package sprite_sched_pkg;

    localparam int X_W_DEF   = 9;
    localparam int Y_W_DEF   = 8;
    localparam int COL_W_DEF = 3;

    localparam logic PASS_ERASE = 1'b0;
    localparam logic PASS_DRAW  = 1'b1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_ADVANCE = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SELECT  = ST_SELECT,
        S_ISSUE   = ST_ISSUE,
        S_WAIT    = ST_WAIT,
        S_RELEASE = ST_RELEASE,
        S_ADVANCE = ST_ADVANCE,
        S_DONE    = ST_DONE
    } state_t;

    // A single-slot build still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_slot_mux.sv
// Combinational selector that picks one slot's x/y/colour out of the packed
// engine buses; its outputs feed the scheduler's VGA output registers.
module sprite_slot_mux
    import sprite_sched_pkg::*;
#(
    parameter int N_SLOTS = 3,
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int COL_W   = COL_W_DEF,
    parameter int IDX_W   = idx_width(N_SLOTS)
) (
    input  logic [IDX_W-1:0]         idx,
    input  logic [N_SLOTS*X_W-1:0]   slot_x,
    input  logic [N_SLOTS*Y_W-1:0]   slot_y,
    input  logic [N_SLOTS*COL_W-1:0] slot_colour,
    output logic [X_W-1:0]           sel_x,
    output logic [Y_W-1:0]           sel_y,
    output logic [COL_W-1:0]         sel_colour
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_x      = slot_x[i*X_W +: X_W];
                sel_y      = slot_y[i*Y_W +: Y_W];
                sel_colour = slot_colour[i*COL_W +: COL_W];
            end
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Two-pass (erase all, then draw all) sequencer sharing one VGA plot port among N sprite engines.
// Optional per-operation watchdog is compiled in with `define SCHED_TIMEOUT_EN.
module sprite_draw_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int N_SLOTS        = 3,
    parameter int X_W            = X_W_DEF,
    parameter int Y_W            = Y_W_DEF,
    parameter int COL_W          = COL_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [N_SLOTS-1:0]       slot_en,
    input  logic [N_SLOTS-1:0]       slot_done,
    input  logic [N_SLOTS*X_W-1:0]   slot_x,
    input  logic [N_SLOTS*Y_W-1:0]   slot_y,
    input  logic [N_SLOTS*COL_W-1:0] slot_colour,
    output logic [N_SLOTS-1:0]       draw_signal,
    output logic [N_SLOTS-1:0]       erase_signal,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [COL_W-1:0]         vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam int               IDX_W    = idx_width(N_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);

    if (N_SLOTS < 1 || N_SLOTS > 8) begin : g_bad_slots
        $error("sprite_draw_scheduler: N_SLOTS must be 1..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("sprite_draw_scheduler: TIMEOUT_CYCLES must fit the 8-bit watchdog");
    end

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx;
    logic                 pass;
    logic [N_SLOTS-1:0]   en_q;
    logic                 pending;
    logic [N_SLOTS-1:0]   onehot;
    logic                 slot_enabled;
    logic                 op_done;
    logic                 start;
    logic                 drive_op;
    logic                 wd_fire;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [COL_W-1:0]     sel_colour;

    assign onehot       = N_SLOTS'(1) << idx;
    assign slot_enabled = |(en_q & onehot);
    assign op_done      = |(slot_done & onehot);
    assign start        = (state == S_IDLE) && (frame_tick || pending);

    sprite_slot_mux #(
        .N_SLOTS (N_SLOTS),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .COL_W   (COL_W),
        .IDX_W   (IDX_W)
    ) u_mux (
        .idx         (idx),
        .slot_x      (slot_x),
        .slot_y      (slot_y),
        .slot_colour (slot_colour),
        .sel_x       (sel_x),
        .sel_y       (sel_y),
        .sel_colour  (sel_colour)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        unique case (state)
            S_IDLE:    if (frame_tick || pending) state_next = S_SELECT;
            S_SELECT:  state_next = slot_enabled ? S_ISSUE : S_ADVANCE;
            S_ISSUE:   state_next = S_WAIT;
            S_WAIT:    if (op_done || wd_fire) state_next = S_RELEASE;
            S_RELEASE: state_next = S_ADVANCE;
            S_ADVANCE: state_next = (idx != LAST_IDX || pass == PASS_ERASE) ? S_SELECT : S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx  <= '0;
            pass <= PASS_ERASE;
            en_q <= '0;
        end else if (start) begin
            en_q <= slot_en;
            pass <= PASS_ERASE;
            idx  <= '0;
        end else if (state == S_ADVANCE) begin
            if (idx != LAST_IDX) begin
                idx <= idx + IDX_W'(1);
            end else if (pass == PASS_ERASE) begin
                pass <= PASS_DRAW;
                idx  <= '0;
            end
        end
    end

    // A tick arriving while a queued tick is being consumed stays queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (state == S_IDLE) begin
            pending <= pending && frame_tick;
        end else if (frame_tick) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
        end
    end

    // Engine handshakes and the plot port are decoded from the next state so they
    // leave registers aligned with ISSUE/WAIT and drop at once on reset.
    assign drive_op = (state_next == S_ISSUE) || (state_next == S_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            draw_signal  <= '0;
            erase_signal <= '0;
            vga_plot     <= 1'b0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_colour   <= '0;
        end else begin
            draw_signal  <= (drive_op && pass == PASS_DRAW)  ? onehot : '0;
            erase_signal <= (drive_op && pass == PASS_ERASE) ? onehot : '0;
            vga_plot     <= (state_next == S_WAIT);
            if (state_next == S_WAIT) begin
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_colour;
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    logic [7:0] wd_cnt;

    assign wd_fire = (state == S_WAIT) && !op_done && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                wd_cnt <= '0;
            else if (state == S_WAIT && wd_cnt != 8'hFF)
                wd_cnt <= wd_cnt + 8'd1;
            if (wd_fire)
                timeout_err <= 1'b1;
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: stimulus queues expected engine
// operations and frame pulses; a monitor pops and compares as the DUT produces them.
module tb_sprite_draw_scheduler;

    localparam int N     = 3;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;
    localparam int TO    = 16;
    localparam int DELAY = 40;

    localparam logic [X_W-1:0]   XS [N] = '{9'h011, 9'h122, 9'h1F3};
    localparam logic [Y_W-1:0]   YS [N] = '{8'h21, 8'h52, 8'hA3};
    localparam logic [COL_W-1:0] CS [N] = '{3'd1, 3'd2, 3'd5};

    typedef enum int {EV_ERASE = 0, EV_DRAW = 1, EV_FRAME = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       slot;
        int       dur;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 frame_tick;
    logic [N-1:0]         slot_en;
    logic [N-1:0]         slot_done;
    logic [N*X_W-1:0]     slot_x;
    logic [N*Y_W-1:0]     slot_y;
    logic [N*COL_W-1:0]   slot_colour;
    logic [N-1:0]         draw_signal;
    logic [N-1:0]         erase_signal;
    logic [X_W-1:0]       vga_x;
    logic [Y_W-1:0]       vga_y;
    logic [COL_W-1:0]     vga_colour;
    logic                 vga_plot;
    logic                 busy;
    logic                 frame_done;
    logic                 overrun;
    logic                 timeout_err;

    ev_t          exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           frames_seen = 0;
    logic [N-1:0] noise = '0;
    logic [N-1:0] hang  = '0;
    int           done_delay = DELAY;

    always #5 clk = ~clk;

    sprite_draw_scheduler #(
        .N_SLOTS        (N),
        .X_W            (X_W),
        .Y_W            (Y_W),
        .COL_W          (COL_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .slot_en      (slot_en),
        .slot_done    (slot_done),
        .slot_x       (slot_x),
        .slot_y       (slot_y),
        .slot_colour  (slot_colour),
        .draw_signal  (draw_signal),
        .erase_signal (erase_signal),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Signal-high cycles seen at the falling edge: ISSUE plus WAIT cycles.
    function automatic int exp_dur(input int slot);
        if (noise[slot]) return 2;
        if (hang[slot])  return TO + 1;
        return done_delay + 1;
    endfunction

    function automatic int lowest(input logic [N-1:0] v);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push_op(input ev_kind_t kind, input int slot);
        ev_t e;
        e.kind = kind;
        e.slot = slot;
        e.dur  = (kind == EV_FRAME) ? 0 : exp_dur(slot);
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [N-1:0] en);
        for (int i = 0; i < N; i++) if (en[i]) push_op(EV_ERASE, i);
        for (int i = 0; i < N; i++) if (en[i]) push_op(EV_DRAW, i);
        push_op(EV_FRAME, 0);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_completed", frames_seen, target);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    // Sprite engine model: pulse slot_done done_delay cycles after its signal rises.
    initial begin
        int           cnt [N];
        logic [N-1:0] prev, cur, pulse;
        prev = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        slot_done = '0;
        forever begin
            @(negedge clk);
            cur   = draw_signal | erase_signal;
            pulse = '0;
            for (int i = 0; i < N; i++) begin
                if (!cur[i]) begin
                    cnt[i] = 0;
                end else if (!prev[i]) begin
                    cnt[i] = done_delay;
                end else if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0 && !hang[i]) pulse[i] = 1'b1;
                end
            end
            prev      = cur;
            slot_done = pulse | noise;
        end
    end

    // Monitor: compares every operation start, its length, the VGA port and frame pulses.
    initial begin
        logic [N-1:0] mprev, cur;
        int           act_cnt, act_dur, s;
        ev_kind_t     kind;
        ev_t          e;
        mprev   = '0;
        act_cnt = 0;
        act_dur = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mprev   = '0;
                act_cnt = 0;
                continue;
            end
            cur = draw_signal | erase_signal;
            check("signals_onehot", int'($countones(draw_signal) + $countones(erase_signal) <= 1), 1);
            if (mprev != '0 && cur != mprev)
                check("op_duration", act_cnt, act_dur);
            if (cur != '0 && cur != mprev) begin
                check("gap_before_op", int'(mprev), 0);
                kind = (draw_signal != '0) ? EV_DRAW : EV_ERASE;
                s    = lowest(cur);
                check("plot_low_in_issue", vga_plot, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_op", int'(kind) * 16 + s, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("op_kind", int'(kind), int'(e.kind));
                    check("op_slot", s, e.slot);
                    act_dur = e.dur;
                end
                act_cnt = 1;
            end else if (cur != '0) begin
                act_cnt++;
            end
            if (vga_plot) begin
                s = lowest(cur);
                check("plot_has_owner", int'(cur != '0), 1);
                check("vga_x", int'(vga_x), int'(XS[s]));
                check("vga_y", int'(vga_y), int'(YS[s]));
                check("vga_colour", int'(vga_colour), int'(CS[s]));
            end
            if (frame_done) begin
                frames_seen++;
                check("busy_at_frame_done", busy, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_done", frames_seen, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_done_kind", int'(EV_FRAME), int'(e.kind));
                end
            end
            mprev = cur;
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete, failures so far %0d", n_fail);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int base;
        int n;
        reset      = 1'b1;
        frame_tick = 1'b0;
        slot_en    = '0;
        for (int i = 0; i < N; i++) begin
            slot_x[i*X_W +: X_W]       = XS[i];
            slot_y[i*Y_W +: Y_W]       = YS[i];
            slot_colour[i*COL_W +: COL_W] = CS[i];
        end
        repeat (3) @(negedge clk);
        check("rst_draw", int'(draw_signal), 0);
        check("rst_erase", int'(erase_signal), 0);
        check("rst_plot", vga_plot, 0);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // All three slots: E0 E1 E2 D0 D1 D2, one frame_done.
        slot_en = 3'b111;
        push_frame(3'b111);
        base = frames_seen;
        tick();
        wait_frames(base + 1, 2000);
        settle();
        check("no_overrun_single", overrun, 0);

        // Slot 1 disabled with its done line stuck high; enable change mid-frame is deferred.
        slot_en = 3'b101;
        noise   = 3'b010;
        push_frame(3'b101);
        base = frames_seen;
        tick();
        repeat (10) @(negedge clk);
        slot_en = 3'b111;
        wait_frames(base + 1, 2000);
        noise = '0;
        settle();
        push_frame(3'b111);
        tick();
        wait_frames(base + 2, 2000);
        settle();

        // Second tick queues, third tick overruns and is dropped.
        slot_en = 3'b001;
        push_frame(3'b001);
        push_frame(3'b001);
        base = frames_seen;
        tick();
        repeat (5) @(negedge clk);
        tick();
        repeat (5) @(negedge clk);
        tick();
        wait_frames(base + 2, 3000);
        repeat (300) @(negedge clk);
        check("only_two_frames", frames_seen, base + 2);
        settle();
        check("overrun_set", overrun, 1);

        // Asynchronous reset while slot 1 is erasing.
        slot_en = 3'b111;
        push_op(EV_ERASE, 0);
        push_op(EV_ERASE, 1);
        tick();
        n = 0;
        while (!erase_signal[1] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_slot1", erase_signal[1], 1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_draw", int'(draw_signal), 0);
        check("async_rst_erase", int'(erase_signal), 0);
        check("async_rst_plot", vga_plot, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_overrun", overrun, 0);
        @(negedge clk);
        check("rst_scoreboard_empty", exp_q.size(), 0);
        reset = 1'b0;
        @(negedge clk);
        push_frame(3'b111);
        base = frames_seen;
        tick();
        wait_frames(base + 1, 2000);
        settle();

        // Back-to-back single-slot ops with done already high during ISSUE; tick in the DONE cycle.
        slot_en = 3'b001;
        noise   = 3'b001;
        push_frame(3'b001);
        push_frame(3'b001);
        base = frames_seen;
        tick();
        n = 0;
        while (!frame_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("first_done_seen", frame_done, 1);
        tick();
        wait_frames(base + 2, 1000);
        noise = '0;
        settle();
        check("no_overrun_done_tick", overrun, 0);

`ifdef SCHED_TIMEOUT_EN
        // Slot 0 never answers: watchdog releases it after TO cycles of WAIT.
        slot_en = 3'b011;
        hang    = 3'b001;
        check("timeout_clear_before", timeout_err, 0);
        push_frame(3'b011);
        base = frames_seen;
        tick();
        wait_frames(base + 1, 2000);
        hang = '0;
        settle();
        check("timeout_set", timeout_err, 1);
`else
        check("timeout_tied_low", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
